// File: rtl/audio_effect_scheduler.sv
// audio_effect_scheduler
//   Arbitrates up to four sound-effect requesters onto one synthesizer note
//   input. Holds a 64-entry note RAM and four (start, length) descriptors
//   loaded over a config write port. It grants one pending effect by fixed
//   priority (lowest index wins) and emits one note byte per tempo tick.
//
// Ports:
//   CLK        system clock (MasterCLK domain)
//   Reset      asynchronous, active-high reset
//   Enable     global enable; 0 aborts playback and flushes pending requests
//   Req[3:0]   per-effect request, sampled every cycle
//   CfgWrEn    config write strobe
//   CfgAddr    bit6=0: note RAM address [5:0]
//              bit6=1: descriptor, [2:1]=effect id, [0]=0 start / 1 length
//   CfgData    write data (descriptors use [5:0])
//   NoteOut    note byte to the synthesizer, 0 = silence
//   NoteValid  1-cycle pulse when NoteOut is updated on a tick
//   Busy       1 while in LOAD or PLAY
//   ActiveId   id of the most recently granted effect
//   DonePulse  1-cycle pulse on normal completion (with the silence note)
//   TempoTick  1-cycle tempo pulse, also used by the soundtrack path
//
// Build option:
//   PREEMPT_EN  when defined, a tick that sees a pending effect of lower index
//               than ActiveId aborts the current effect and starts the new one
//               on that same tick. When undefined, lower-index requests wait.

module audio_effect_scheduler #(
   parameter int TEMPO_DIV = 20000000,
   parameter int NOTE_AW   = 6
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic       Enable,
   input  logic [3:0] Req,
   input  logic       CfgWrEn,
   input  logic [6:0] CfgAddr,
   input  logic [7:0] CfgData,
   output logic [7:0] NoteOut,
   output logic       NoteValid,
   output logic       Busy,
   output logic [1:0] ActiveId,
   output logic       DonePulse,
   output logic       TempoTick
);

   localparam int TW    = (TEMPO_DIV > 1) ? $clog2(TEMPO_DIV) : 1;
   localparam int DEPTH = 1 << NOTE_AW;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_t;

   state_t             state, state_nxt;
   logic [TW-1:0]      tcnt;
   logic [7:0]         ram [DEPTH];
   logic [NOTE_AW-1:0] desc_start [4];
   logic [NOTE_AW-1:0] desc_len   [4];
   logic [3:0]         pend;
   logic [3:0]         len_nz;
   logic [3:0]         clr_mask;
   logic [1:0]         gnt_id;
   logic               gnt_any;
   logic [NOTE_AW-1:0] addr_q;
   logic [NOTE_AW-1:0] rem_q;
   logic               preempt;
   logic               take_idle;
   logic               emit;
   logic               finish;
   logic               ram_we;
   logic               desc_we;

   // ---------------- tempo counter (free-running, ignores Enable)
   assign TempoTick = (tcnt == TW'(TEMPO_DIV - 1));

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset)          tcnt <= '0;
      else if (TempoTick) tcnt <= '0;
      else                tcnt <= tcnt + TW'(1);
   end

   // ---------------- config port
   assign ram_we  = CfgWrEn && !CfgAddr[6];
   assign desc_we = CfgWrEn &&  CfgAddr[6];

   // RAM has no reset; reads are asynchronous, so a write landing on a tick
   // edge is seen by the next read only, and the tick captures the old byte.
   always_ff @(posedge CLK) begin
      if (ram_we) ram[CfgAddr[NOTE_AW-1:0]] <= CfgData;
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < 4; i++) begin
            desc_start[i] <= '0;
            desc_len[i]   <= '0;
         end
      end else if (desc_we) begin
         if (CfgAddr[0]) desc_len[CfgAddr[2:1]]   <= CfgData[NOTE_AW-1:0];
         else            desc_start[CfgAddr[2:1]] <= CfgData[NOTE_AW-1:0];
      end
   end

   // ---------------- pending set + fixed-priority pick
   always_comb begin
      for (int i = 0; i < 4; i++) len_nz[i] = (desc_len[i] != '0);
   end

   always_comb begin
      gnt_any = |pend;
      gnt_id  = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (pend[i]) gnt_id = 2'(i);
   end

`ifdef PREEMPT_EN
   // Lowest pending index is gnt_id, so a lower-priority-index request exists
   // exactly when gnt_id < ActiveId.
   assign preempt = Enable && TempoTick && (state != S_IDLE) && gnt_any &&
                    (gnt_id < ActiveId);
`else
   assign preempt = 1'b0;
`endif

   // ---------------- FSM: state register
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // ---------------- FSM: next state
   always_comb begin
      state_nxt = state;
      if (!Enable) state_nxt = S_IDLE;
      else begin
         case (state)
            S_IDLE:  if (gnt_any)   state_nxt = S_LOAD;
            S_LOAD:  if (TempoTick) state_nxt = S_PLAY;
            S_PLAY:  if (preempt)   state_nxt = S_PLAY;
                     else if (TempoTick && rem_q == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // ---------------- FSM: control outputs
   always_comb begin
      take_idle = Enable && (state == S_IDLE) && gnt_any;
      emit      = Enable && TempoTick && !preempt &&
                  ((state == S_LOAD) || ((state == S_PLAY) && rem_q != '0));
      finish    = Enable && TempoTick && !preempt &&
                  (state == S_PLAY) && (rem_q == '0);
      clr_mask  = (take_idle || preempt) ? (4'b0001 << gnt_id) : 4'b0000;
      Busy      = (state != S_IDLE);
   end

   // ---------------- datapath
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         pend      <= '0;
         NoteOut   <= '0;
         NoteValid <= 1'b0;
         DonePulse <= 1'b0;
         ActiveId  <= '0;
         addr_q    <= '0;
         rem_q     <= '0;
      end else begin
         NoteValid <= 1'b0;
         DonePulse <= 1'b0;
         // A request in the grant cycle re-queues the same effect.
         pend <= Enable ? ((pend & ~clr_mask) | (Req & len_nz)) : 4'b0000;
         if (!Enable) begin
            NoteOut <= '0;
         end else if (take_idle) begin
            ActiveId <= gnt_id;
            addr_q   <= desc_start[gnt_id];
            rem_q    <= desc_len[gnt_id];
         end else if (preempt) begin
            ActiveId  <= gnt_id;
            NoteOut   <= ram[desc_start[gnt_id]];
            NoteValid <= 1'b1;
            addr_q    <= desc_start[gnt_id] + NOTE_AW'(1);
            rem_q     <= desc_len[gnt_id] - NOTE_AW'(1);
         end else if (emit) begin
            NoteOut   <= ram[addr_q];
            NoteValid <= 1'b1;
            addr_q    <= addr_q + NOTE_AW'(1);   // wraps 63 -> 0
            rem_q     <= rem_q - NOTE_AW'(1);
         end else if (finish) begin
            NoteOut   <= '0;
            NoteValid <= 1'b1;
            DonePulse <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_audio_effect_scheduler.sv
module tb_audio_effect_scheduler;

   logic       CLK = 1'b0;
   logic       Reset, Enable, CfgWrEn;
   logic [3:0] Req;
   logic [6:0] CfgAddr;
   logic [7:0] CfgData;
   logic [7:0] NoteOut;
   logic       NoteValid, Busy, DonePulse, TempoTick;
   logic [1:0] ActiveId;

   int total = 0;
   int bad   = 0;

   logic [7:0] n;
   logic       d, b, qv, qb;
   logic [1:0] id;
   int         k;

   audio_effect_scheduler #(.TEMPO_DIV(4), .NOTE_AW(6)) dut (
      .CLK(CLK), .Reset(Reset), .Enable(Enable), .Req(Req),
      .CfgWrEn(CfgWrEn), .CfgAddr(CfgAddr), .CfgData(CfgData),
      .NoteOut(NoteOut), .NoteValid(NoteValid), .Busy(Busy),
      .ActiveId(ActiveId), .DonePulse(DonePulse), .TempoTick(TempoTick)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cfg(input logic [6:0] a, input logic [7:0] v);
      CfgWrEn = 1'b1; CfgAddr = a; CfgData = v;
      @(negedge CLK);
      CfgWrEn = 1'b0;
   endtask

   task automatic pulse_req(input logic [3:0] r);
      Req = r;
      @(negedge CLK);
      Req = 4'b0000;
   endtask

   // Waits (bounded) for the next NoteValid pulse and returns what it saw.
   task automatic wait_note(output logic [7:0] note, output logic dn,
                            output logic [1:0] aid, output logic bsy);
      int c;
      c = 0;
      while (!NoteValid && c < 40) begin @(negedge CLK); c++; end
      chk("note_timeout", 32'(c < 40), 1);
      note = NoteOut; dn = DonePulse; aid = ActiveId; bsy = Busy;
      @(negedge CLK);
   endtask

   // Watches a window for any NoteValid or Busy activity.
   task automatic quiet(input int cycles, output logic any_v, output logic any_b);
      any_v = 1'b0; any_b = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         any_v |= NoteValid; any_b |= Busy;
         @(negedge CLK);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      Reset = 1'b1; Enable = 1'b0; Req = '0; CfgWrEn = 1'b0; CfgAddr = '0; CfgData = '0;
      repeat (3) @(negedge CLK);
      chk("rst_note",  NoteOut,   0);
      chk("rst_valid", NoteValid, 0);
      chk("rst_busy",  Busy,      0);
      chk("rst_id",    ActiveId,  0);
      chk("rst_done",  DonePulse, 0);
      chk("rst_tick",  TempoTick, 0);
      Reset = 1'b0;

      // tempo period
      k = 0;
      while (!TempoTick && k < 10) begin @(negedge CLK); k++; end
      chk("tick_seen", TempoTick, 1);
      @(negedge CLK); k = 1;
      while (!TempoTick && k < 10) begin @(negedge CLK); k++; end
      chk("tick_period", k, 4);

      // configuration
      cfg(7'd10, 8'h21); cfg(7'd11, 8'h22); cfg(7'd12, 8'h23);
      cfg(7'd20, 8'h50); cfg(7'd30, 8'h60);
      cfg(7'd62, 8'h30); cfg(7'd63, 8'h31); cfg(7'd0, 8'h32);
      cfg(7'd1, 8'h33);  cfg(7'd2, 8'h34);
      cfg(7'h40, 8'd20); cfg(7'h41, 8'd1);   // effect0
      cfg(7'h42, 8'd10); cfg(7'h43, 8'd3);   // effect1
      cfg(7'h44, 8'd30); cfg(7'h45, 8'd1);   // effect2
      cfg(7'h46, 8'd62); cfg(7'h47, 8'd3);   // effect3
      Enable = 1'b1;

      // 1: basic three-note effect
      pulse_req(4'b0010);
      @(negedge CLK);
      chk("t1_busy_start", Busy, 1);
      wait_note(n, d, id, b);
      chk("t1_n0", n, 8'h21); chk("t1_d0", d, 0); chk("t1_id", id, 1); chk("t1_b0", b, 1);
      wait_note(n, d, id, b);
      chk("t1_n1", n, 8'h22); chk("t1_d1", d, 0);
      wait_note(n, d, id, b);
      chk("t1_n2", n, 8'h23); chk("t1_b2", b, 1);
      wait_note(n, d, id, b);
      chk("t1_n3", n, 8'h00); chk("t1_d3", d, 1); chk("t1_b3", b, 0);

      // 2: simultaneous requests, priority
      pulse_req(4'b0101);
      wait_note(n, d, id, b);
      chk("t2_n0", n, 8'h50); chk("t2_id0", id, 0);
      wait_note(n, d, id, b);
      chk("t2_s0", n, 8'h00); chk("t2_d0", d, 1);
      wait_note(n, d, id, b);
      chk("t2_n1", n, 8'h60); chk("t2_id1", id, 2);
      wait_note(n, d, id, b);
      chk("t2_s1", n, 8'h00); chk("t2_d1", d, 1);

      // 3: address wrap
      pulse_req(4'b1000);
      wait_note(n, d, id, b);
      chk("t3_n0", n, 8'h30); chk("t3_id", id, 3);
      wait_note(n, d, id, b);
      chk("t3_n1", n, 8'h31);
      wait_note(n, d, id, b);
      chk("t3_n2", n, 8'h32);
      wait_note(n, d, id, b);
      chk("t3_s", n, 8'h00); chk("t3_d", d, 1);

      // 4: Enable dropped during second note, pending Req[2] discarded
      pulse_req(4'b0010);
      wait_note(n, d, id, b);
      chk("t4_n0", n, 8'h21);
      pulse_req(4'b0100);
      wait_note(n, d, id, b);
      chk("t4_n1", n, 8'h22);
      Enable = 1'b0;
      @(negedge CLK);
      chk("t4_note0", NoteOut, 0);
      chk("t4_busy0", Busy, 0);
      chk("t4_done0", DonePulse, 0);
      chk("t4_valid0", NoteValid, 0);
      Enable = 1'b1;
      quiet(16, qv, qb);
      chk("t4_no_valid", qv, 0); chk("t4_no_busy", qb, 0);

      // 5: zero-length effect ignored
      cfg(7'h43, 8'd0);
      pulse_req(4'b0010);
      quiet(16, qv, qb);
      chk("t5_no_valid", qv, 0); chk("t5_no_busy", qb, 0);

      // 6: lower-index request during a long effect
      cfg(7'h47, 8'd5);
      pulse_req(4'b1000);
      wait_note(n, d, id, b);
      chk("t6_n0", n, 8'h30); chk("t6_id0", id, 3);
      pulse_req(4'b0001);
`ifdef PREEMPT_EN
      wait_note(n, d, id, b);
      chk("t6_pre_n", n, 8'h50); chk("t6_pre_id", id, 0); chk("t6_pre_d", d, 0);
      wait_note(n, d, id, b);
      chk("t6_pre_s", n, 8'h00); chk("t6_pre_sd", d, 1); chk("t6_pre_sid", id, 0);
      quiet(16, qv, qb);
      chk("t6_no_requeue", qv, 0);
`else
      wait_note(n, d, id, b);
      chk("t6_n1", n, 8'h31); chk("t6_id1", id, 3);
      wait_note(n, d, id, b); chk("t6_n2", n, 8'h32);
      wait_note(n, d, id, b); chk("t6_n3", n, 8'h33);
      wait_note(n, d, id, b); chk("t6_n4", n, 8'h34);
      wait_note(n, d, id, b);
      chk("t6_s3", n, 8'h00); chk("t6_d3", d, 1); chk("t6_sid3", id, 3);
      wait_note(n, d, id, b);
      chk("t6_n0e", n, 8'h50); chk("t6_id0e", id, 0);
      wait_note(n, d, id, b);
      chk("t6_s0", n, 8'h00); chk("t6_d0", d, 1);
`endif

      // async reset mid-playback
      pulse_req(4'b1000);
      wait_note(n, d, id, b);
      #2 Reset = 1'b1;
      #1;
      chk("rst_mid_note", NoteOut, 0);
      chk("rst_mid_busy", Busy, 0);
      chk("rst_mid_id", ActiveId, 0);
      @(negedge CLK);
      Reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/audio_effect_scheduler.md
Name: audio_effect_scheduler

Overview:
Sequences and arbitrates sound-effect playback for the effect synthesizer. Up to four requesters (game events from the processor) share a single synthesizer note input. The block holds a 64-entry note RAM and four effect descriptors (start, length), all loaded over a config write port. It picks one pending effect by fixed priority and emits one note byte per tempo tick; the note byte feeds the synthesizer InputData.

Parameters:
TEMPO_DIV, 20000000, CLK cycles per tempo tick (100 MHz / 5 Hz); valid range >= 2
NOTE_AW, 6, note RAM address width (64 entries)

Ports:
CLK  in  1  system clock (MasterCLK domain)
Reset  in  1  asynchronous, active-high reset
Enable  in  1  global effect enable; 0 aborts and flushes
Req  in  4  per-effect request; sampled every cycle
CfgWrEn  in  1  config write strobe
CfgAddr  in  7  bit6=0: note RAM addr[5:0]; bit6=1: descriptor, [2:1]=effect id, [0]=0 start / 1 length
CfgData  in  8  write data; start/length use [5:0]
NoteOut  out  8  current note byte to synthesizer; 0 = silence
NoteValid  out  1  1-cycle pulse when NoteOut is updated on a tick
Busy  out  1  1 in LOAD or PLAY
ActiveId  out  2  id of the effect currently granted
DonePulse  out  1  1-cycle pulse on normal completion
TempoTick  out  1  1-cycle tick pulse, exported for the soundtrack path

Behaviour:
- Reset: all outputs 0. State IDLE. Pending 0. Tempo counter 0. Descriptors 0. RAM contents undefined.
- Tempo counter: free-running 0..TEMPO_DIV-1. TempoTick=1 in the cycle the counter equals TEMPO_DIV-1, then the counter wraps to 0. Runs regardless of Enable.
- Pending[i]: set when Req[i]=1 and length[i]!=0; length 0 means the request is ignored. Cleared on grant of i. A request on the same cycle as its grant wins, so the effect is queued again.
- Arbitration: fixed priority, lowest index highest.
- IDLE: if Enable and pending!=0, go to LOAD next cycle. Latch ActiveId, addr=start[id], remaining=length[id]. Clear pending[id].
- LOAD: wait for TempoTick. On tick: NoteOut<=ram[addr], NoteValid=1, addr<=addr+1 mod 64, remaining<=remaining-1. Go to PLAY.
- PLAY, on tick with remaining!=0: emit the next note as in LOAD.
- PLAY, on tick with remaining==0: NoteOut<=0, NoteValid=1, DonePulse=1. Go to IDLE.
- Timing: an effect of length L produces L note ticks and then one silence tick.
- Address wraps 63->0 inside an effect; a start+length beyond 63 is legal.
- RAM: asynchronous read. A write to the address being read on a tick edge outputs the old data.
- Descriptor writes while an effect plays affect only later grants; the active effect uses latched copies.
- Enable=0 (any state): next cycle go to IDLE, NoteOut=0, pending cleared. No NoteValid, no DonePulse. Requests are ignored while Enable=0.
- Reset mid-playback: all outputs drop to 0 asynchronously.

Optional Feature:
PREEMPT_EN.
- Defined: in LOAD or PLAY, a tick that sees a pending index lower than ActiveId aborts the current effect (no DonePulse). On that same tick it grants the new id: ActiveId updated, NoteOut<=ram[start[new]], NoteValid=1, addr=start+1, remaining=length-1, state PLAY. The aborted effect is not re-queued.
- Undefined: lower-index requests stay pending until the current effect completes.

Test Plan (TEMPO_DIV=4):
1. Load RAM[10..12]=0x21,0x22,0x23; effect1 start=10, length=3; Enable=1; pulse Req[1] -> NoteOut 0x21,0x22,0x23,0x00 on 4 successive ticks. NoteValid on each. DonePulse with the 0x00. Busy 1 throughout, then 0.
2. Req[2] and Req[0] in the same cycle, both with length 1 -> effect0 plays first, then effect2 after DonePulse. ActiveId 0 then 2.
3. Effect3 start=62, length=3, RAM[62]=0x30, RAM[63]=0x31, RAM[0]=0x32 -> notes 0x30,0x31,0x32 (address wrap).
4. Enable dropped during the second note -> next cycle NoteOut=0, Busy=0, no DonePulse. A pending Req[2] is discarded.
5. Req[1] with length[1]=0 -> no grant, Busy stays 0, NoteValid never pulses.
6. PREEMPT_EN: effect3 length 5 playing, Req[0] raised after the first note -> next tick outputs effect0's first note, ActiveId=0, no DonePulse for effect3. Without PREEMPT_EN, effect0 starts only after effect3's silence tick.
